// File: rtl/if_fetch_unit_if.sv
// ============================================================================
//  Module : if_fetch_unit_if
//  Brief  : Single-outstanding instruction-memory request/response bundle.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
//  Module : if_fetch_unit
//  Brief  : Instruction fetch stage feeding IF/ID; optional counters via FETCH_PERF_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PC_Stall,
    input  logic                   Redirect,
    input  logic [31:0]            Redirect_PC,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            instOut,
    output logic [31:0]            PC,
    output logic                   Fetch_Valid,
    output logic [31:0]            perf_inst_cnt,
    output logic [31:0]            perf_bubble_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic        deliver;
    logic [31:0] dlv_inst;
    logic [31:0] dlv_pc;
    logic [31:0] target_pc;

    assign target_pc = Redirect_PC & ~32'h0000_0003;

    assign imem.req    = (state_q == S_REQ) && !rst;
    assign imem.addr   = fetch_pc_q;
    assign instOut     = inst_q;
    assign PC          = pc_q;
    assign Fetch_Valid = valid_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pend_pc_d   = pend_pc_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        deliver     = 1'b0;
        dlv_inst    = hold_inst_q;
        dlv_pc      = hold_pc_q;

        case (state_q)
            S_REQ: begin
                if (Redirect) begin
                    fetch_pc_d = target_pc;
                    if (imem.gnt) state_d = S_DROP;
                end else if (imem.gnt) begin
                    pend_pc_d = fetch_pc_q;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Redirect) begin
                    fetch_pc_d = target_pc;
                    state_d    = imem.rvalid ? S_REQ : S_DROP;
                end else if (imem.rvalid) begin
                    fetch_pc_d = pend_pc_q + 32'd4;
                    if (PC_Stall) begin
                        hold_inst_d = imem.rdata;
                        hold_pc_d   = pend_pc_q;
                        state_d     = S_HOLD;
                    end else begin
                        deliver  = 1'b1;
                        dlv_inst = imem.rdata;
                        dlv_pc   = pend_pc_q;
                        state_d  = S_REQ;
                    end
                end
            end
            S_DROP: begin
                if (Redirect) fetch_pc_d = target_pc;
                if (imem.rvalid) state_d = S_REQ;
            end
            S_HOLD: begin
                if (Redirect) begin
                    fetch_pc_d = target_pc;
                    state_d    = S_REQ;
                end else if (!PC_Stall) begin
                    deliver = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect squashes the wrong-path output even while IF/ID is stalled.
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (Redirect) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (deliver) begin
            inst_d  = dlv_inst;
            pc_d    = dlv_pc;
            valid_d = 1'b1;
        end else if (!PC_Stall) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            pend_pc_q   <= RESET_PC;
            hold_inst_q <= NOP_INST;
            hold_pc_q   <= RESET_PC;
            inst_q      <= NOP_INST;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pend_pc_q   <= pend_pc_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_inst_cnt_q, perf_inst_cnt_d;
    logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;
    logic        bubble;

    always_comb begin
        bubble            = Redirect || (!deliver && !PC_Stall);
        perf_inst_cnt_d   = perf_inst_cnt_q + (deliver && !Redirect ? 32'd1 : 32'd0);
        perf_bubble_cnt_d = perf_bubble_cnt_q + (bubble ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_cnt_q   <= 32'd0;
            perf_bubble_cnt_q <= 32'd0;
        end else begin
            perf_inst_cnt_q   <= perf_inst_cnt_d;
            perf_bubble_cnt_q <= perf_bubble_cnt_d;
        end
    end

    assign perf_inst_cnt   = perf_inst_cnt_q;
    assign perf_bubble_cnt = perf_bubble_cnt_q;
`else
    assign perf_inst_cnt   = 32'h0;
    assign perf_bubble_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
//  Module : tb_if_fetch_unit
//  Brief  : Directed cycle-table bench for if_fetch_unit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PC_Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_PC = 32'h0;
    logic [31:0] instOut;
    logic [31:0] PC;
    logic        Fetch_Valid;
    logic [31:0] perf_inst_cnt;
    logic [31:0] perf_bubble_cnt;

    if_fetch_unit_if imem ();

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .PC_Stall        (PC_Stall),
        .Redirect        (Redirect),
        .Redirect_PC     (Redirect_PC),
        .imem            (imem.master),
        .instOut         (instOut),
        .PC              (PC),
        .Fetch_Valid     (Fetch_Valid),
        .perf_inst_cnt   (perf_inst_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   step_no = 0;

    task automatic v(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                     input logic g, input logic rv, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_inst,
                     input logic [31:0] e_pc, input logic e_valid);
        vecs.push_back('{r, s, rd, rpc, g, rv, rdata, e_req, e_addr, e_inst, e_pc, e_valid});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, step_no, got, exp);
    endtask

    // Drive one cycle's inputs, check request side before the edge and the
    // output register after it.
    task automatic run(input vec_t t);
        @(negedge clk);
        rst         = t.rst;
        PC_Stall    = t.stall;
        Redirect    = t.redir;
        Redirect_PC = t.rpc;
        imem.gnt    = t.gnt;
        imem.rvalid = t.rv;
        imem.rdata  = t.rdata;
        #1;
        chk("imem_req", {31'b0, imem.req}, {31'b0, t.e_req});
        chk("imem_addr", imem.addr, t.e_addr);
        @(posedge clk);
        #1;
        chk("instOut", instOut, t.e_inst);
        chk("PC", PC, t.e_pc);
        chk("Fetch_Valid", {31'b0, Fetch_Valid}, {31'b0, t.e_valid});
        step_no++;
    endtask

    initial begin
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        @(posedge clk);

        //  rst st rd rpc           g  rv rdata          req addr          inst   pc            vld
        v(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        NOP,   32'h0,        0);
        // steady state: mem[i] = i
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        NOP,   32'h0,        0);
        v(0, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0, 32'h0,        1);
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        NOP,   32'h0,        0);
        v(0, 0, 0, 32'h0,        1, 1, 32'h1,        0, 32'h4,        32'h1, 32'h4,        1);
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8,        NOP,   32'h4,        0);
        // stall spanning rvalid for addr 8 -> HOLD, no request issued
        v(0, 1, 0, 32'h0,        1, 1, 32'h2,        0, 32'h8,        NOP,   32'h4,        0);
        v(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'hC,        NOP,   32'h4,        0);
        v(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'hC,        NOP,   32'h4,        0);
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hC,        32'h2, 32'h8,        1);
        // stall holds a valid output
        v(0, 1, 0, 32'h0,        1, 0, 32'h0,        1, 32'hC,        32'h2, 32'h8,        1);
        v(0, 0, 0, 32'h0,        0, 1, 32'h3,        0, 32'hC,        32'h3, 32'hC,        1);
        // redirect in WAIT, response arrives two cycles later
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h10,       NOP,   32'hC,        0);
        v(0, 0, 1, 32'h100,      0, 0, 32'h0,        0, 32'h10,       NOP,   32'hC,        0);
        v(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      NOP,   32'hC,        0);
        v(0, 0, 0, 32'h0,        0, 1, 32'hDEAD,     0, 32'h100,      NOP,   32'hC,        0);
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      NOP,   32'hC,        0);
        v(0, 0, 0, 32'h0,        0, 1, 32'h40,       0, 32'h100,      32'h40, 32'h100,     1);
        // redirect with rvalid same cycle (unaligned target), then redirect while ungranted
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h104,      NOP,   32'h100,      0);
        v(0, 0, 1, 32'h203,      0, 1, 32'hBAD,      0, 32'h104,      NOP,   32'h100,      0);
        v(0, 0, 1, 32'h300,      0, 0, 32'h0,        1, 32'h200,      NOP,   32'h100,      0);
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h300,      NOP,   32'h100,      0);
        v(0, 0, 0, 32'h0,        0, 1, 32'hC0,       0, 32'h300,      32'hC0, 32'h300,     1);
        // redirect overrides stall hold; fetch at top of address space wraps
        v(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       1, 32'h304,      NOP,   32'h300,      0);
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC, NOP,  32'h300,      0);
        v(0, 0, 0, 32'h0,        0, 1, 32'h55,       0, 32'hFFFF_FFFC, 32'h55, 32'hFFFF_FFFC, 1);
        v(0, 0, 1, 32'h80,       0, 0, 32'h0,        1, 32'h0,        NOP,   32'hFFFF_FFFC, 0);
        // reset mid-WAIT; late rvalid must be ignored
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h80,       NOP,   32'hFFFF_FFFC, 0);
        v(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h80,       NOP,   32'h0,        0);
        v(0, 0, 0, 32'h0,        0, 1, 32'h77,       1, 32'h0,        NOP,   32'h0,        0);
        v(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        NOP,   32'h0,        0);
        v(0, 0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h0,        32'h0, 32'h0,        1);

        for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

        // Hand-written: redirect while a stalled word sits in HOLD discards it.
        run('{0, 0, 0, 32'h0,  1, 0, 32'h0, 1, 32'h4,  NOP,   32'h0,  0});
        run('{0, 1, 0, 32'h0,  0, 1, 32'h1, 0, 32'h4,  NOP,   32'h0,  0});
        run('{0, 1, 1, 32'h40, 0, 0, 32'h0, 0, 32'h8,  NOP,   32'h0,  0});
        run('{0, 0, 0, 32'h0,  0, 0, 32'h0, 1, 32'h40, NOP,   32'h0,  0});
        run('{0, 0, 0, 32'h0,  1, 0, 32'h0, 1, 32'h40, NOP,   32'h0,  0});
        run('{0, 0, 0, 32'h0,  0, 1, 32'h10, 0, 32'h40, 32'h10, 32'h40, 1});

        // Hand-written: 10 deliveries, first 3 request cycles stalled -> 7 bubbles.
        run('{1, 0, 0, 32'h0,  0, 0, 32'h0, 0, 32'h44, NOP,   32'h0,  0});
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = 32'(i) * 32'd4;
            if (i == 0)
                run('{0, 1, 0, 32'h0, 1, 0, 32'h0, 1, a, NOP, 32'h0, 0});
            else if (i < 3)
                run('{0, 1, 0, 32'h0, 1, 0, 32'h0, 1, a, 32'(i - 1), a - 32'd4, 1});
            else
                run('{0, 0, 0, 32'h0, 1, 0, 32'h0, 1, a, NOP, a - 32'd4, 0});
            run('{0, 0, 0, 32'h0, 0, 1, 32'(i), 0, a, 32'(i), a, 1});
        end
`ifdef FETCH_PERF_EN
        chk("perf_inst_cnt", perf_inst_cnt, 32'd10);
        chk("perf_bubble_cnt", perf_bubble_cnt, 32'd7);
`else
        chk("perf_inst_cnt", perf_inst_cnt, 32'd0);
        chk("perf_bubble_cnt", perf_bubble_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage directly upstream of the IF/ID pipeline register. Owns the program counter and issues single-outstanding requests to a variable-latency instruction memory. Absorbs stalls and branch/jump redirects, and presents registered {instOut, PC} to IF/ID, with a NOP (32'h00000013) whenever no valid instruction is available.

Parameters:
RESET_PC  32'h0000_0000  fetch address after reset
NOP_INST  32'h0000_0013  RV32I NOP (addi x0,x0,0) driven on bubbles

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, synchronous, active-high
PC_Stall  input  1  hazard unit hold; IF/ID is not capturing this cycle
Redirect  input  1  taken branch/jump resolved in EX
Redirect_PC  input  32  target address for Redirect
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, word-aligned
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid for the single outstanding request
imem_rdata  input  32  instruction word
instOut  output  32  instruction to IF/ID (registered)
PC  output  32  address of instOut (registered)
Fetch_Valid  output  1  instOut/PC hold a real (non-bubble) instruction
perf_inst_cnt  output  32  delivered-instruction count (optional feature)
perf_bubble_cnt  output  32  bubble-cycle count (optional feature)

Behaviour:
- Reset (rst=1 at posedge): state<=REQ, fetch_pc<=RESET_PC, instOut<=NOP_INST, PC<=RESET_PC, Fetch_Valid<=0, hold buffer cleared. imem_req=0 while rst=1. imem is reset by the same rst; any in-flight response is discarded (rvalid ignored outside WAIT/DROP).
- imem_req=1 only in REQ; imem_addr=fetch_pc (may change while ungranted, on Redirect).
- At most one outstanding request; a request is outstanding from the gnt cycle until the rvalid cycle.
- States:
  REQ: gnt & !Redirect -> pend_pc<=fetch_pc, WAIT. gnt & Redirect -> fetch_pc<=Redirect_PC, DROP. !gnt & Redirect -> fetch_pc<=Redirect_PC, stay REQ.
  WAIT: Redirect (with or without rvalid) -> fetch_pc<=Redirect_PC; rvalid ? REQ : DROP; response discarded. rvalid & !PC_Stall -> deliver(imem_rdata, pend_pc), fetch_pc<=pend_pc+4, REQ. rvalid & PC_Stall -> hold buffer<={imem_rdata, pend_pc}, fetch_pc<=pend_pc+4, HOLD.
  DROP: rvalid -> discard, REQ. Redirect -> fetch_pc<=Redirect_PC (stay DROP, or REQ if rvalid the same cycle).
  HOLD: Redirect -> discard buffer, fetch_pc<=Redirect_PC, REQ. !PC_Stall -> deliver(buffer), REQ. else stay.
- Output register: deliver sets instOut, PC, Fetch_Valid=1 for exactly one cycle. Any non-deliver cycle with PC_Stall=0: instOut<=NOP_INST, Fetch_Valid<=0, PC held. While PC_Stall=1: instOut/PC/Fetch_Valid held unchanged (IF/ID retries).
- Redirect in any state: output register <= NOP_INST, Fetch_Valid<=0 (wrong-path squash); overrides PC_Stall hold.
- Priority: rst > Redirect > rvalid/gnt > PC_Stall.
- fetch_pc+4 is a 32-bit modulo add; 32'hFFFF_FFFC wraps to 0. Redirect_PC[1:0] is forced to 2'b00.
- Steady state, 1-cycle gnt and 1-cycle rvalid: one instruction every 2 cycles (REQ->WAIT->REQ).

Optional Feature:
FETCH_PERF_EN defined: perf_inst_cnt increments on every deliver; perf_bubble_cnt increments on every cycle the output register loads NOP_INST with Fetch_Valid=0. Both are 32-bit, wrap at 2^32, and clear on rst. Not defined: no counter logic; both ports are tied to 32'h0.

Test Plan:
- Reset, gnt=1 always, rvalid 1 cycle after gnt, mem[i]=i -> imem_addr 0,4,8; Fetch_Valid pulses with PC=0,4,8, instOut=0,1,2; bubbles are NOP 32'h00000013.
- PC_Stall=1 for 3 cycles spanning the rvalid for addr 8 -> instOut/PC hold the prior value, state HOLD; instruction 8 delivered the cycle after stall release; no request issued during HOLD.
- Redirect to 32'h0000_0100 in WAIT (rvalid 2 cycles later) -> that response discarded; next imem_addr=0x100; output NOP, Fetch_Valid=0 until 0x100 delivered.
- Redirect and rvalid in the same cycle; separately, Redirect while gnt=0 in REQ -> data dropped in both cases; imem_addr switches to the target immediately; exactly one request is outstanding.
- rst asserted mid-WAIT with a later rvalid -> response ignored; first request after reset is at RESET_PC; outputs at reset values.
- FETCH_PERF_EN: 10 deliveries and 7 bubbles -> perf_inst_cnt=10, perf_bubble_cnt=7. Without the macro, both read 0.
